// File: rtl/baud_timer_pkg.sv
// rtl/baud_timer_pkg.sv - shared types and constants for the baud timer
// Contents: state_t (IDLE/RUN/DONE), mode_t (PERIODIC/ONESHOT), MIN_DIV.
package baud_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } mode_t;

    // Smallest usable period; anything below is clamped up to this.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/baud_div_shadow.sv
// rtl/baud_div_shadow.sv - active divisor with run-time pending reload
// Ports:
//   clk, rst      clock, async active-low reset
//   div_load, div strobe and value to capture (clamped to MIN_DIV)
//   run           timer is in RUN: loads are deferred to the pending register
//   boundary      last cycle of a period; pending value is applied here
//   div_q         active divisor
module baud_div_shadow
    import baud_timer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div,
    input  logic             run,
    input  logic             boundary,
    output logic [WIDTH-1:0] div_q
);

    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    logic [WIDTH-1:0] div_c;
    logic [WIDTH-1:0] pend;
    logic             pend_v;

    assign div_c = (div < MIN_DIV_W) ? MIN_DIV_W : div;

    // Outside RUN a pending value (left over from a stop) is applied at once,
    // so the next start never sees a stale divisor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= WIDTH'(DEFAULT_DIV);
            pend   <= '0;
            pend_v <= 1'b0;
        end else if (div_load && (!run || boundary)) begin
            div_q  <= div_c;
            pend_v <= 1'b0;
        end else if (div_load) begin
            pend   <= div_c;
            pend_v <= 1'b1;
        end else if (pend_v && (!run || boundary)) begin
            div_q  <= pend;
            pend_v <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_timer.sv
// rtl/baud_timer.sv - periodic / one-shot baud tick timer
// Optional feature: define BAUD_TIMER_MIDTICK_EN to enable mid_tick.
// Ports:
//   clk, rst          clock, async active-low reset
//   start, stop       arm/restart and abort pulses (stop wins)
//   mode              0 periodic, 1 one-shot (latched on start)
//   div, div_load     period in clk cycles and its capture strobe
//   n_periods         one-shot period count (latched on start, 0 means 1)
//   tick, mid_tick    registered period-boundary / mid-period pulses
//   busy, done        in RUN / sticky one-shot completion
module baud_timer
    import baud_timer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 434,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    input  logic [CNT_W-1:0] n_periods,
    output logic             tick,
    output logic             mid_tick,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    mode_t            mode_q;
    logic [CNT_W-1:0] n_q;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] tcnt, tcnt_nxt;
    logic [WIDTH-1:0] div_q;
    logic             tick_nxt;
    logic             done_q, done_nxt;
    logic             wrap;
    logic             final_tick;
    logic             go;

    baud_div_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .div_load (div_load),
        .div      (div),
        .run      (state == RUN),
        .boundary (wrap),
        .div_q    (div_q)
    );

    assign go         = start && !stop;
    assign wrap       = (state == RUN) && (cnt == div_q - 1'b1);
    assign final_tick = (mode_q == ONESHOT) && (tcnt == n_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= PERIODIC;
            n_q    <= CNT_W'(1);
            cnt    <= '0;
            tcnt   <= '0;
            tick   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tcnt   <= tcnt_nxt;
            tick   <= tick_nxt;
            done_q <= done_nxt;
            if (go) begin
                mode_q <= mode_t'(mode);
                n_q    <= (n_periods == '0) ? CNT_W'(1) : n_periods;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop)
            state_nxt = IDLE;
        else if (start)
            state_nxt = RUN;
        else if (wrap && final_tick)
            state_nxt = DONE;
    end

    // start and stop both clear the counters and suppress the tick that
    // would otherwise land on the same edge.
    always_comb begin
        cnt_nxt  = '0;
        tcnt_nxt = tcnt;
        tick_nxt = wrap && !stop && !start;
        done_nxt = done_q;
        if (stop || start) begin
            tcnt_nxt = '0;
        end else if (state == RUN) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            if (wrap)
                tcnt_nxt = tcnt + 1'b1;
        end
        if (go)
            done_nxt = 1'b0;
        else if (wrap && !stop && final_tick)
            done_nxt = 1'b1;
    end

    assign busy = (state == RUN);
    // The flag itself survives stop; it is only hidden while idle.
    assign done = done_q && (state != IDLE);

`ifdef BAUD_TIMER_MIDTICK_EN
    logic             mid_q;
    logic [WIDTH-1:0] half;

    assign half = div_q >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mid_q <= 1'b0;
        else
            mid_q <= (state == RUN) && !stop && !start && (cnt == half - 1'b1);
    end

    assign mid_tick = mid_q;
`else
    assign mid_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_timer.sv
// tb/tb_baud_timer.sv - scoreboard bench for baud_timer
module tb_baud_timer;

`ifdef BAUD_TIMER_MIDTICK_EN
    localparam bit MID_EN = 1'b1;
`else
    localparam bit MID_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] div = '0;
    logic        div_load = 1'b0;
    logic [7:0]  n_periods = '0;
    logic        tick, mid_tick, busy, done;

    baud_timer #(
        .WIDTH       (16),
        .DEFAULT_DIV (434),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .div       (div),
        .div_load  (div_load),
        .n_periods (n_periods),
        .tick      (tick),
        .mid_tick  (mid_tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tick_q[$];
    int mid_q[$];
    int vectors = 0;
    int errors  = 0;
    int exp_t;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (tick) begin
            if (tick_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL tick_unexpected: tick at edge %0d, none expected", cyc);
            end else begin
                exp_t = tick_q.pop_front();
                chk("tick_time", cyc, exp_t);
            end
        end
        if (mid_tick) begin
            if (mid_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL mid_unexpected: mid_tick at edge %0d, none expected", cyc);
            end else begin
                exp_t = mid_q.pop_front();
                chk("mid_time", cyc, exp_t);
            end
        end
    end

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Expected tick/mid edges for one run started at edge e0 and ended
    // (by stop, restart or reset) at edge s. fin is the final one-shot tick.
    task automatic model(input int e0, input int d0, input bit rl, input int rl_at,
                         input int d1, input bit md, input int n, input int s,
                         output int fin);
        int cur, t, cnt, nn;
        bit pend;
        cur  = clampd(d0);
        t    = e0;
        cnt  = 0;
        nn   = (n == 0) ? 1 : n;
        pend = rl;
        fin  = 32'h7fff_ffff;
        forever begin
            if (t + cur / 2 >= s) break;
            if (MID_EN) mid_q.push_back(t + cur / 2);
            t += cur;
            if (t >= s) break;
            tick_q.push_back(t);
            cnt++;
            if (md && cnt == nn) begin
                fin = t;
                break;
            end
            if (pend && rl_at <= t) begin
                cur  = clampd(d1);
                pend = 1'b0;
            end
        end
    endtask

    task automatic load_div(input int d);
        @(negedge clk);
        div      = d[15:0];
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    // Starts at edge e0 and drives len-1 further edges; the caller decides
    // what happens at edge e0+len.
    task automatic run_seg(input int d0, input bit rl, input int rl_off, input int d1,
                           input bit md, input int n, input int len);
        int e0, fin;
        bit exp_done;
        @(negedge clk);
        mode      = md;
        n_periods = n[7:0];
        start     = 1'b1;
        stop      = 1'b0;
        div_load  = 1'b0;
        e0        = cyc + 1;
        model(e0, d0, rl, e0 + rl_off, d1, md, n, e0 + len, fin);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rl && i == rl_off) begin
                div      = d1[15:0];
                div_load = 1'b1;
            end else begin
                div_load = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        exp_done = (fin <= e0 + len - 1);
        chk("busy_run", int'(busy), int'(!exp_done));
        chk("done_run", int'(done), int'(exp_done));
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        chk("tick_missing", tick_q.size(), 0);
        chk("mid_missing", mid_q.size(), 0);
    endtask

    task automatic stop_and_drain();
        @(negedge clk);
        start    = 1'b0;
        div_load = 1'b0;
        stop     = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("busy_after_stop", int'(busy), 0);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d, d1, md, n, len, rl, rl_off;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({tick, mid_tick, busy, done}), 0);
        rst = 1'b1;

        // Periodic at the reset divisor, then reset while running.
        run_seg(434, 0, 1, 0, 0, 0, 900);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({tick, mid_tick, busy, done}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle_after_reset_busy", int'(busy), 0);
        drain();

        // One-shot div=4, three periods.
        load_div(4);
        run_seg(4, 0, 1, 0, 1, 3, 20);
        stop_and_drain();

        // One-shot with n_periods=0 behaves as one period.
        load_div(3);
        run_seg(3, 0, 1, 0, 1, 0, 10);
        stop_and_drain();

        // Run-time reload 10 -> 6 at E0+3.
        load_div(10);
        run_seg(10, 1, 3, 6, 0, 0, 25);
        stop_and_drain();

        // Stop on the tick edge suppresses the tick.
        load_div(10);
        run_seg(10, 0, 1, 0, 0, 0, 10);
        stop_and_drain();

        // start and stop together, from IDLE and from RUN.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", int'(busy), 0);
        load_div(5);
        run_seg(5, 0, 1, 0, 0, 0, 7);
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_run", int'(busy), 0);
        drain();

        // div=0 clamps to 2.
        load_div(0);
        run_seg(0, 0, 1, 0, 0, 0, 11);
        stop_and_drain();

        // Restart in RUN on what would have been a tick edge.
        load_div(7);
        run_seg(7, 0, 1, 0, 0, 0, 14);
        run_seg(7, 0, 1, 0, 1, 2, 30);
        stop_and_drain();

        // Randomised runs.
        for (int it = 0; it < 14; it++) begin
            d      = $urandom_range(24, 0);
            d1     = $urandom_range(24, 0);
            md     = $urandom_range(1, 0);
            n      = $urandom_range(4, 0);
            len    = $urandom_range(70, 3);
            rl     = $urandom_range(1, 0);
            rl_off = $urandom_range(len - 1, 1);
            load_div(d);
            run_seg(d, rl[0], rl_off, d1, md[0], n, len);
            if (rl == 0 && $urandom_range(1, 0) == 1) begin
                md  = $urandom_range(1, 0);
                n   = $urandom_range(4, 0);
                len = $urandom_range(50, 3);
                run_seg(d, 1'b0, 1, 0, md[0], n, len);
            end
            stop_and_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
